// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: frame sequencer sitting in front of the V1/V2 convolutional
// encoders and the Viterbi decoder. Pulls FRAME_LEN payload bits from a
// valid/ready source, appends TAIL_LEN zero flush bits, holds the decoder in
// flush for DRAIN_CYC cycles and pulses done at frame end.
// Optional feature macro: CONV_FRAME_CTRL_ABORT_EN adds the abort input and the
// aborted output.
module conv_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int TAIL_LEN  = 2,
    parameter int DRAIN_CYC = 8,
    parameter int CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             enc_sel,
`ifdef CONV_FRAME_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             src_valid,
    input  logic             src_data,
    output logic             src_ready,
    output logic             enc_clr,
    output logic             enc_en,
    output logic             enc_in,
    output logic             enc_sel_q,
    output logic             dec_flush,
    output logic             busy,
    output logic             done,
`ifdef CONV_FRAME_CTRL_ABORT_EN
    output logic             aborted,
`endif
    output logic [CNT_W-1:0] bit_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        TAIL,
        DRAIN,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] LastPayload = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] TailLen     = CNT_W'(TAIL_LEN);
    localparam logic [CNT_W-1:0] LastDrain   = CNT_W'(DRAIN_CYC - 1);
    localparam logic [CNT_W-1:0] CntOne      = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   phaseCnt_q, phaseCnt_d;
    logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic               encEn_q, encEn_d;
    logic               encIn_q, encIn_d;
    logic               encClr_q, encClr_d;
    logic               encSel_q, encSel_d;
    logic               decFlush_q, decFlush_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef CONV_FRAME_CTRL_ABORT_EN
    logic               abortSeen_q, abortSeen_d;
    logic               aborted_q, aborted_d;
`endif

    // The source may only hand over a bit while payload is being loaded.
    assign src_ready = (state_q == LOAD);

    assign enc_clr   = encClr_q;
    assign enc_en    = encEn_q;
    assign enc_in    = encIn_q;
    assign enc_sel_q = encSel_q;
    assign dec_flush = decFlush_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_cnt   = bitCnt_q;
`ifdef CONV_FRAME_CTRL_ABORT_EN
    assign aborted   = aborted_q;
`endif

    // Next-state logic: phaseCnt counts handshakes in LOAD, tail bits in TAIL
    // and drain cycles in DRAIN. TAIL lasts TAIL_LEN+1 cycles because its first
    // cycle still carries the registered strobe of the last payload bit.
    always_comb begin
        state_d    = state_q;
        phaseCnt_d = phaseCnt_q;
        bitCnt_d   = bitCnt_q;
        encEn_d    = 1'b0;
        encIn_d    = 1'b0;
        encSel_d   = encSel_q;
`ifdef CONV_FRAME_CTRL_ABORT_EN
        abortSeen_d = abortSeen_q;
        aborted_d   = aborted_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CLR;
                    encSel_d   = enc_sel;
                    bitCnt_d   = '0;
                    phaseCnt_d = '0;
`ifdef CONV_FRAME_CTRL_ABORT_EN
                    abortSeen_d = 1'b0;
                    aborted_d   = 1'b0;
`endif
                end
            end
            CLR: begin
                state_d    = LOAD;
                phaseCnt_d = '0;
            end
            LOAD: begin
                if (src_valid) begin
                    encEn_d  = 1'b1;
                    encIn_d  = src_data;
                    bitCnt_d = bitCnt_q + CntOne;
                    if (phaseCnt_q == LastPayload) begin
                        phaseCnt_d = '0;
                        state_d    = (TAIL_LEN == 0) ? DRAIN : TAIL;
                    end else begin
                        phaseCnt_d = phaseCnt_q + CntOne;
                    end
                end
            end
            TAIL: begin
                if (phaseCnt_q == TailLen) begin
                    state_d    = DRAIN;
                    phaseCnt_d = '0;
                end else begin
                    encEn_d    = 1'b1;
                    encIn_d    = 1'b0;
                    bitCnt_d   = bitCnt_q + CntOne;
                    phaseCnt_d = phaseCnt_q + CntOne;
                end
            end
            DRAIN: begin
                if (phaseCnt_q == LastDrain) begin
                    state_d    = DONE;
                    phaseCnt_d = '0;
                end else begin
                    phaseCnt_d = phaseCnt_q + CntOne;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef CONV_FRAME_CTRL_ABORT_EN
        if (abort && ((state_q == CLR) || (state_q == LOAD) || (state_q == TAIL))) begin
            state_d     = TAIL;
            phaseCnt_d  = '0;
            bitCnt_d    = '0;
            encEn_d     = 1'b0;
            encIn_d     = 1'b0;
            abortSeen_d = 1'b1;
        end
        if ((state_q == DRAIN) && (state_d == DONE)) begin
            aborted_d = abortSeen_q;
        end
`endif
    end

    // State-aligned flags are registered from the next state so they line up with it.
    always_comb begin
        encClr_d   = (state_d == CLR);
        decFlush_d = (state_d == DRAIN);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            phaseCnt_q <= '0;
            bitCnt_q   <= '0;
            encEn_q    <= 1'b0;
            encIn_q    <= 1'b0;
            encClr_q   <= 1'b0;
            encSel_q   <= 1'b0;
            decFlush_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef CONV_FRAME_CTRL_ABORT_EN
            abortSeen_q <= 1'b0;
            aborted_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            phaseCnt_q <= phaseCnt_d;
            bitCnt_q   <= bitCnt_d;
            encEn_q    <= encEn_d;
            encIn_q    <= encIn_d;
            encClr_q   <= encClr_d;
            encSel_q   <= encSel_d;
            decFlush_q <= decFlush_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef CONV_FRAME_CTRL_ABORT_EN
            abortSeen_q <= abortSeen_d;
            aborted_q   <= aborted_d;
`endif
        end
    end

endmodule

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
- Frame sequencer in front of the convolutional encoders (V1/V2) and the Viterbi decoder in System.
- Pulls FRAME_LEN payload bits from a valid/ready source and drives the encoder's input bit and advance strobe.
- Appends TAIL_LEN zero tail bits to flush the encoder back to state 0, then waits DRAIN_CYC cycles so the decoder can finish traceback.
- Pulses done at frame end; selects which encoder version is active for the frame.

Parameters:
- FRAME_LEN, 16, payload bits per frame (>=1).
- TAIL_LEN, 2, zero tail bits (constraint length minus 1); 0 means no tail.
- DRAIN_CYC, 8, decoder drain cycles after the last tail bit (>=1).
- CNT_W, 8, counter width; must hold FRAME_LEN+TAIL_LEN and DRAIN_CYC.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- start  in  1  frame request; sampled only in IDLE.
- enc_sel  in  1  encoder choice (0 = V1, 1 = V2); latched when start is accepted.
- src_valid  in  1  source bit valid.
- src_data  in  1  source bit.
- src_ready  out  1  controller accepts a bit this cycle.
- enc_clr  out  1  one-cycle clear of the encoder shift register.
- enc_en  out  1  encoder advance strobe.
- enc_in  out  1  bit presented to the encoder, qualified by enc_en.
- enc_sel_q  out  1  latched encoder select, held for the whole frame.
- dec_flush  out  1  high for the whole DRAIN state; tells the decoder to trace back.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle frame-complete pulse.
- bit_cnt  out  CNT_W  encoder bits issued this frame (payload plus tail).

Behaviour:
- Reset (async, RST_N=0):
  - State goes to IDLE.
  - All outputs are 0, including bit_cnt and enc_sel_q.
  - Reset asserted mid-frame abandons the frame immediately; no done pulse is produced.
- States: IDLE, CLR, LOAD, TAIL, DRAIN, DONE. All outputs are registered except src_ready, which is decoded from state.
- IDLE:
  - start=1 moves to CLR.
  - enc_sel is latched into enc_sel_q.
  - bit_cnt is cleared to 0.
- CLR: enc_clr=1 for exactly this one cycle, then LOAD.
- LOAD:
  - src_ready=1.
  - Each handshake (src_valid & src_ready) sets enc_en=1 and enc_in=src_data on the next cycle, and increments bit_cnt. Handshake-to-strobe latency is 1 cycle.
  - Cycles with src_valid=0 give enc_en=0 on the next cycle.
  - On the FRAME_LEN-th handshake: go to TAIL, or to DRAIN if TAIL_LEN=0. src_ready drops in that next cycle.
- TAIL:
  - src_ready=0.
  - Issues TAIL_LEN consecutive enc_en=1 strobes with enc_in=0, with no gaps; bit_cnt increments on each.
  - Then goes to DRAIN.
- DRAIN:
  - enc_en=0, dec_flush=1.
  - Stays exactly DRAIN_CYC cycles, then goes to DONE.
- DONE:
  - done=1 for one cycle, then IDLE.
  - bit_cnt holds FRAME_LEN+TAIL_LEN until the next start is accepted.
- Boundary conditions:
  - start outside IDLE is ignored; this includes the DONE cycle.
  - enc_sel changes mid-frame do not affect enc_sel_q.
  - FRAME_LEN=1: LOAD accepts exactly one bit.
  - src_valid held high gives back-to-back strobes.
  - src_valid high outside LOAD is not consumed.

Optional Feature:
- Macro: CONV_FRAME_CTRL_ABORT_EN.
- When defined:
  - Adds input port abort (1 bit).
  - abort=1 in CLR, LOAD or TAIL jumps to TAIL with the bit counters reset to 0, so the encoder is still flushed with TAIL_LEN zeros. The frame then ends normally through DRAIN and DONE.
  - Adds output aborted, set with done for that frame and cleared on the next start.
  - abort in IDLE, DRAIN or DONE is ignored.
- When undefined: neither port exists and the behaviour is exactly as described above.

Test Plan:
- Reset, then start=1 with enc_sel=1 and src_valid held high, data 1,0,1,1,... -> enc_clr one cycle; 16 enc_en strobes follow src_data delayed by 1 cycle; then 2 strobes with enc_in=0; dec_flush high for 8 cycles; done one cycle; bit_cnt=18; enc_sel_q=1 throughout.
- src_valid toggling 1/0 each cycle during LOAD -> enc_en alternates; LOAD lasts 32 cycles; total strobes still 18.
- start pulsed during LOAD and again on the done cycle -> both ignored; busy stays high; exactly one done pulse.
- RST_N dropped to 0 after the 5th payload bit -> all outputs 0 immediately; no done pulse; a fresh start afterwards runs a full 18-bit frame.
- TAIL_LEN=0, FRAME_LEN=1 -> one strobe; DRAIN entered the next cycle; done after 8 drain cycles; bit_cnt=1.
- With CONV_FRAME_CTRL_ABORT_EN: abort after the 3rd payload bit -> exactly 2 zero tail strobes follow; done and aborted both 1; bit_cnt=2 at done.
